// File: rtl/or_reduce_scheduler.sv
// or_reduce_scheduler: shares one registered DW-bit OR-reduction unit between NREQ requesters.
// Round-robin by default; define OR_SCHED_FIXED_PRIO_EN for fixed priority (lowest index wins).
//
// state   | meaning
// IDLE    | arbitrate among req_valid, accept one operand
// ISSUE   | operand held on or_in_o while the OR unit samples it
// CAPTURE | register OR result and owner id into the response
// RESP    | hold response until rsp_ready
module or_reduce_scheduler #(
  parameter int NREQ = 4,
  parameter int DW   = 6,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [DW-1:0]      or_in_o,
  input  logic               or_out_i,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic               rsp_data
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  logic [1:0]     state_q;
  logic [IDW-1:0] id_q;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] cand;
  logic [DW-1:0]  winner_data;
  logic           accept;

  // Later candidates overwrite earlier ones, so the loop runs from farthest to nearest.
  always_comb begin
    winner = '0;
    cand   = '0;
`ifdef OR_SCHED_FIXED_PRIO_EN
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IDW'(k);
      if (req_valid[cand]) winner = cand;
    end
`else
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDW'((int'(last_grant) + k) % NREQ);
      if (req_valid[cand]) winner = cand;
    end
`endif
  end

  always_comb begin
    winner_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (winner == IDW'(k)) winner_data = req_data[k*DW +: DW];
    end
  end

  assign accept = (state_q == S_IDLE) && (|req_valid);

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[winner] = 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      or_in_o    <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= 1'b0;
      id_q       <= '0;
      last_grant <= IDW'(NREQ - 1);
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            or_in_o    <= winner_data;
            id_q       <= winner;
            last_grant <= winner;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          rsp_data  <= or_out_i;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          or_in_o   <= '0;
          state_q   <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_or_reduce_scheduler.sv
// Scoreboard bench for or_reduce_scheduler: reference arbiter/timing model plus response monitor.
`timescale 1ns/1ps
module tb_or_reduce_scheduler;
  localparam int NREQ = 4;
  localparam int DW   = 6;
  localparam int IDW  = 2;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [DW-1:0]      or_in_o;
  logic               or_out_i;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic               rsp_data;

  logic        rst8;
  logic [7:0]  req_valid8;
  logic [47:0] req_data8;
  logic [7:0]  req_ready8;
  logic [5:0]  or_in8;
  logic        or_out8;
  logic        rsp_valid8;
  logic [2:0]  rsp_id8;
  logic        rsp_data8;

  or_reduce_scheduler #(.NREQ(NREQ), .DW(DW)) u_dut (
    .clk_in(clk_in), .rst_in(rst_in), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .or_in_o(or_in_o), .or_out_i(or_out_i), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data));

  or_reduce_scheduler #(.NREQ(8), .DW(6)) u_dut8 (
    .clk_in(clk_in), .rst_in(rst8), .req_valid(req_valid8), .req_data(req_data8),
    .req_ready(req_ready8), .or_in_o(or_in8), .or_out_i(or_out8), .rsp_valid(rsp_valid8),
    .rsp_ready(1'b1), .rsp_id(rsp_id8), .rsp_data(rsp_data8));

  always #5 clk_in = ~clk_in;

  // Behavioural OR units with one cycle of latency.
  always @(posedge clk_in) or_out_i <= |or_in_o;
  always @(posedge clk_in) or_out8  <= |or_in8;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int last);
    logic [IDW-1:0] idx;
`ifdef OR_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) begin
      idx = IDW'(i);
      if (v[idx]) return i;
    end
`else
    for (int i = 1; i <= NREQ; i++) begin
      idx = IDW'((last + i) % NREQ);
      if (v[idx]) return int'(idx);
    end
`endif
    return -1;
  endfunction

  typedef struct {int id; logic d;} rsp_t;
  rsp_t exp_q[$];
  int   grant_log[$];

  bit            m_busy = 1'b0;
  int            m_age  = 0;
  int            m_last = NREQ - 1;
  logic [DW-1:0] m_data = '0;

  // Reference model: one op at a time, response presented three samples after acceptance.
  always @(negedge clk_in) begin
    logic [NREQ-1:0] exp_ready;
    logic [DW-1:0]   exp_or;
    int w;
    if (rst_in) begin
      m_busy = 1'b0;
      m_age  = 0;
      m_last = NREQ - 1;
      exp_q.delete();
    end else begin
      if (m_busy) m_age++;
      w = pick(req_valid, m_last);
      exp_ready = '0;
      if (!m_busy && w >= 0) exp_ready[w] = 1'b1;
      exp_or = (m_busy && (m_age == 1 || m_age == 2)) ? m_data : '0;
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      check("or_in_o", 64'(or_in_o), 64'(exp_or));
      check("rsp_valid", 64'(rsp_valid), 64'(m_busy && m_age >= 3));
      if (!m_busy && w >= 0) begin
        m_busy = 1'b1;
        m_age  = 0;
        m_last = w;
        m_data = req_data[w*DW +: DW];
        exp_q.push_back('{w, |m_data});
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) grant_log.push_back(i);
      end else if (m_busy && m_age >= 3 && rsp_ready) begin
        m_busy = 1'b0;
      end
    end
  end

  // Response monitor: compares whatever the DUT presents against the queue head.
  always @(negedge clk_in) begin
    if (!rst_in && rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected actual id=%0d data=%0b required=none", rsp_id, rsp_data);
      end else begin
        check("rsp_id", 64'(rsp_id), 64'(exp_q[0].id));
        check("rsp_data", 64'(rsp_data), 64'(exp_q[0].d));
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    cyc(2);
    rst_in = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order[5];
    int g8[$];
    int r8id[$];
    logic r8d[$];

    rst_in = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b1;
    rst8 = 1'b1; req_valid8 = '0; req_data8 = '0;
    cyc(2);
    check("reset_or_in_o", 64'(or_in_o), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_id", 64'(rsp_id), 64'd0);
    check("reset_rsp_data", 64'(rsp_data), 64'd0);
    check("reset_req_ready", 64'(req_ready), 64'd0);
    rst_in = 1'b0;

    // Single request, all-zero operand.
    req_valid = 4'b0001;
    req_data  = '0;
    cyc(1);
    req_valid = '0;
    cyc(6);

    // All requesters held valid with MSB-only operands.
    do_reset();
    grant_log.delete();
    req_valid = 4'hF;
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = 6'b100000;
    cyc(18);
    req_valid = '0;
    cyc(6);
`ifdef OR_SCHED_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    check("grant_count", 64'(grant_log.size() >= 5), 64'd1);
    for (int i = 0; i < 5; i++)
      if (i < grant_log.size()) check("grant_order", 64'(grant_log[i]), 64'(exp_order[i]));

    // Response backpressure.
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = 6'($urandom);
    cyc(12);
    rsp_ready = 1'b1;
    cyc(2);
    req_valid = '0;
    cyc(6);

    // Reset while the scheduler is in CAPTURE.
    do_reset();
    req_valid = 4'b0010;
    req_data[1*DW +: DW] = 6'b010101;
    cyc(1);
    req_valid = '0;
    cyc(1);
    rst_in = 1'b1;
    cyc(1);
    rst_in = 1'b0;
    check("midrst_or_in_o", 64'(or_in_o), 64'd0);
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    req_valid = 4'b1001;
    #1;
    check("post_reset_grant", 64'(req_ready), 64'b0001);
    cyc(1);
    req_valid = '0;
    cyc(6);

    // Eight requesters: wrap-around from the reset pointer.
    req_valid8 = 8'h81;
    for (int i = 0; i < 8; i++) req_data8[i*6 +: 6] = 6'b000001;
    rst8 = 1'b0;
    for (int c = 0; c < 16 && g8.size() < 2; c++) begin
      @(negedge clk_in);
      for (int i = 0; i < 8; i++) if (req_ready8[i]) g8.push_back(i);
      if (rsp_valid8) begin
        r8id.push_back(int'(rsp_id8));
        r8d.push_back(rsp_data8);
      end
    end
    check("nreq8_grant_count", 64'(g8.size()), 64'd2);
    if (g8.size() >= 2) begin
      check("nreq8_first", 64'(g8[0]), 64'd0);
`ifdef OR_SCHED_FIXED_PRIO_EN
      check("nreq8_second", 64'(g8[1]), 64'd0);
`else
      check("nreq8_second", 64'(g8[1]), 64'd7);
`endif
    end
    check("nreq8_rsp_seen", 64'(r8id.size() >= 1), 64'd1);
    if (r8id.size() >= 1) begin
      check("nreq8_rsp_id", 64'(r8id[0]), 64'd0);
      check("nreq8_rsp_data", 64'(r8d[0]), 64'd1);
    end
    #1;
    req_valid8 = '0;
    rst8 = 1'b1;

    // Randomized traffic with random backpressure.
    @(posedge clk_in); #1;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) != 0) req_valid = NREQ'($urandom_range(0, 15));
      for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = DW'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 7);
      cyc(1);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    cyc(10);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
